// File: rtl/func_eval_accumulator.sv
// Command front-end and running-sum sequencer for the function-evaluation datapath.
// Issues LANES-wide operand batches, buffers returned terms, and accumulates them through one shared FP adder.
module func_eval_accumulator #(
    parameter int FLT_DATA_WIDTH = 32,
    parameter int LANES          = 2,
    parameter int DEPTH          = 8,
    parameter int CNT_WIDTH      = 8,
    parameter int N_WIDTH        = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clk_en,
    input  logic                              start,
    input  logic [N_WIDTH-1:0]                n,
    input  logic [LANES*FLT_DATA_WIDTH-1:0]   x_in,
    output logic                              pipe_start,
    output logic [LANES*FLT_DATA_WIDTH-1:0]   pipe_x,
    input  logic                              term_valid,
    output logic                              term_ready,
    input  logic [FLT_DATA_WIDTH-1:0]         term_half,
    input  logic [FLT_DATA_WIDTH-1:0]         term_cos,
    output logic                              add_start,
    output logic [FLT_DATA_WIDTH-1:0]         add_a,
    output logic [FLT_DATA_WIDTH-1:0]         add_b,
    input  logic                              add_done,
    input  logic [FLT_DATA_WIDTH-1:0]         add_result,
    output logic [FLT_DATA_WIDTH-1:0]         result,
    output logic                              done,
    output logic                              err,
    output logic                              busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]          DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [CNT_WIDTH:0]   LANES_W = (CNT_WIDTH+1)'(LANES);
    localparam logic [CNT_WIDTH:0]   CNT_MAX = {1'b0, {CNT_WIDTH{1'b1}}};
    localparam logic [N_WIDTH-1:0]   CMD_CLEAR = N_WIDTH'(0);
    localparam logic [N_WIDTH-1:0]   CMD_GO    = N_WIDTH'(1);
    localparam logic [N_WIDTH-1:0]   CMD_READ  = N_WIDTH'(2);

    typedef enum logic [2:0] {
        S_IDLE, S_GO_ISSUE, S_CLEAR_WAIT, S_READ_WAIT, S_READ_ADD, S_DONE
    } main_state_t;

    typedef enum logic [1:0] {
        A_IDLE, A_HALF, A_COS, A_FINAL
    } acc_state_t;

    main_state_t state, state_next;
    acc_state_t  acc_state, acc_next;
    logic        err_q, err_next;
    logic        add_start_q;

    logic [CNT_WIDTH-1:0]      pending;
    logic [CNT_WIDTH:0]        pend_sum;
    logic [FLT_DATA_WIDTH-1:0] half_sum, cos_sum, cur_cos;

    logic [FLT_DATA_WIDTH-1:0] mem_half [DEPTH];
    logic [FLT_DATA_WIDTH-1:0] mem_cos  [DEPTH];
    logic [AW-1:0]             wr_ptr, rd_ptr;
    logic [AW:0]               count;

    logic full, fifo_empty, push, pop, quiescent, go_fits, issue, final_launch, adder_ack;

    assign full         = (count == DEPTH_W);
    assign fifo_empty   = (count == '0);
    assign term_ready   = !full;
    assign push         = clk_en && term_valid && !full;
    assign quiescent    = (pending == '0) && fifo_empty && (acc_state == A_IDLE);
    assign go_fits      = ({1'b0, pending} + LANES_W) <= CNT_MAX;
    assign issue        = clk_en && (state == S_GO_ISSUE) && go_fits;
    assign final_launch = clk_en && (state == S_READ_WAIT) && quiescent;
    // The final READ add and term accumulation never share the adder: READ_ADD blocks pops.
    assign pop          = clk_en && (acc_state == A_IDLE) && !fifo_empty && (state != S_READ_ADD);
    assign adder_ack    = clk_en && add_done;

    assign pipe_start = issue;
    assign add_start  = add_start_q && clk_en;
    assign done       = clk_en && (state == S_DONE);
    assign err        = done && err_q;
    assign busy       = (state != S_IDLE);

    always_comb begin
        state_next = state;
        err_next   = err_q;
        case (state)
            S_IDLE: begin
                if (clk_en && start) begin
                    err_next = 1'b0;
                    case (n)
                        CMD_CLEAR: state_next = S_CLEAR_WAIT;
                        CMD_GO:    state_next = S_GO_ISSUE;
                        CMD_READ:  state_next = S_READ_WAIT;
                        default: begin
                            state_next = S_DONE;
                            err_next   = 1'b1;
                        end
                    endcase
                end
            end
            S_GO_ISSUE: begin
                if (clk_en) begin
                    state_next = S_DONE;
                    err_next   = !go_fits;
                end
            end
            S_CLEAR_WAIT: if (clk_en && quiescent) state_next = S_DONE;
            S_READ_WAIT:  if (final_launch) state_next = S_READ_ADD;
            S_READ_ADD:   if (adder_ack && acc_state == A_FINAL) state_next = S_DONE;
            S_DONE:       if (clk_en) state_next = S_IDLE;
            default:      state_next = S_IDLE;
        endcase
    end

    always_comb begin
        acc_next = acc_state;
        case (acc_state)
            A_IDLE: begin
                if (final_launch)  acc_next = A_FINAL;
                else if (pop)      acc_next = A_HALF;
            end
            A_HALF:  if (adder_ack) acc_next = A_COS;
            A_COS:   if (adder_ack) acc_next = A_IDLE;
            A_FINAL: if (adder_ack) acc_next = A_IDLE;
            default: acc_next = A_IDLE;
        endcase
    end

    // Pending count: +LANES on issue, -1 per accepted term, floor at zero.
    always_comb begin
        pend_sum = {1'b0, pending} + (issue ? LANES_W : '0);
        if (push && pend_sum != '0)
            pend_sum = pend_sum - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_half[wr_ptr] <= term_half;
            mem_cos[wr_ptr]  <= term_cos;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            acc_state   <= A_IDLE;
            err_q       <= 1'b0;
            add_start_q <= 1'b0;
            add_a       <= '0;
            add_b       <= '0;
            pipe_x      <= '0;
            result      <= '0;
            half_sum    <= '0;
            cos_sum     <= '0;
            cur_cos     <= '0;
            pending     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else if (clk_en) begin
            state       <= state_next;
            acc_state   <= acc_next;
            err_q       <= err_next;
            add_start_q <= 1'b0;
            pending     <= pend_sum[CNT_WIDTH-1:0];

            if (state == S_IDLE && start && n == CMD_GO)
                pipe_x <= x_in;

            case (acc_state)
                A_IDLE: begin
                    if (final_launch) begin
                        add_start_q <= 1'b1;
                        add_a       <= half_sum;
                        add_b       <= cos_sum;
                    end else if (pop) begin
                        add_start_q <= 1'b1;
                        add_a       <= half_sum;
                        add_b       <= mem_half[rd_ptr];
                        cur_cos     <= mem_cos[rd_ptr];
                    end
                end
                A_HALF: begin
                    if (add_done) begin
                        half_sum    <= add_result;
                        add_start_q <= 1'b1;
                        add_a       <= cos_sum;
                        add_b       <= cur_cos;
                    end
                end
                A_COS:   if (add_done) cos_sum <= add_result;
                A_FINAL: if (add_done) result  <= add_result;
                default: ;
            endcase

            if (state == S_CLEAR_WAIT && quiescent) begin
                half_sum <= '0;
                cos_sum  <= '0;
            end

            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

endmodule

// File: tb/tb_func_eval_accumulator.sv
// Directed bench for func_eval_accumulator: stub pipeline, behavioural FP adder, command table plus corner sequences.
module tb_func_eval_accumulator;

    localparam int LIMIT = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk_en = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  n = 2'd0;
    logic [63:0] x_in = '0;
    logic        pipe_start;
    logic [63:0] pipe_x;
    logic        term_valid = 1'b0;
    logic        term_ready;
    logic [31:0] term_half = '0;
    logic [31:0] term_cos = '0;
    logic        add_start;
    logic [31:0] add_a, add_b;
    logic        add_done;
    logic [31:0] add_result;
    logic [31:0] result;
    logic        done, err, busy;

    int tests = 0;
    int fails = 0;
    int pipe_cnt = 0;
    int add_lat = 2;
    logic add_stall = 1'b0;

    func_eval_accumulator dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .start(start), .n(n), .x_in(x_in),
        .pipe_start(pipe_start), .pipe_x(pipe_x),
        .term_valid(term_valid), .term_ready(term_ready), .term_half(term_half), .term_cos(term_cos),
        .add_start(add_start), .add_a(add_a), .add_b(add_b), .add_done(add_done), .add_result(add_result),
        .result(result), .done(done), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (pipe_start) pipe_cnt <= pipe_cnt + 1;

    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        e = int'(b[30:23]) - 127;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        for (int i = 0; i < e; i++) m = m * 2.0;
        for (int i = 0; i > e; i--) m = m / 2.0;
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        real    a;
        int     e;
        longint m;
        logic   s;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 127;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        m = longint'((a - 1.0) * 8388608.0);
        if (m >= 8388608) begin m = 0; e++; end
        return {s, e[7:0], m[22:0]};
    endfunction

    // Behavioural variable-latency FP adder; stall freezes the countdown.
    initial begin
        logic [31:0] op_a, op_b;
        int   op_cnt;
        logic op_pend;
        op_pend = 1'b0; op_cnt = 0; op_a = '0; op_b = '0;
        add_done = 1'b0; add_result = '0;
        forever begin
            @(negedge clk);
            add_done = 1'b0;
            if (op_pend && !add_stall) begin
                if (op_cnt <= 1) begin
                    add_done   = 1'b1;
                    add_result = r2f(f2r(op_a) + f2r(op_b));
                    op_pend    = 1'b0;
                end else begin
                    op_cnt--;
                end
            end
            if (add_start) begin
                op_pend = 1'b1; op_a = add_a; op_b = add_b; op_cnt = add_lat;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cmd(input logic [1:0] c, input logic [63:0] x, output logic e);
        int dur;
        @(negedge clk);
        n = c; x_in = x; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dur = 0;
        while (!done && dur < LIMIT) begin @(negedge clk); dur++; end
        check("cmd_done_seen", done, 1'b1);
        e = err;
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
    endtask

    task automatic push(input logic [31:0] h, input logic [31:0] c);
        int w;
        @(negedge clk);
        term_valid = 1'b1; term_half = h; term_cos = c;
        w = 0;
        while (!term_ready && w < LIMIT) begin @(negedge clk); w++; end
        check("push_ready", term_ready, 1'b1);
        @(posedge clk); #1;
        term_valid = 1'b0;
    endtask

    task automatic check_outputs_reset(input string tag);
        check({tag, "_result"}, result, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_pipe_start"}, pipe_start, 0);
        check({tag, "_pipe_x"}, pipe_x, 0);
        check({tag, "_add_start"}, add_start, 0);
        check({tag, "_add_ab"}, {add_a, add_b}, 0);
        check({tag, "_term_ready"}, term_ready, 1);
    endtask

    typedef struct {
        logic [1:0]  c;
        logic [63:0] x;
        int          npush;
        logic [31:0] h0, c0, h1, c1;
        logic        exp_err;
        int          exp_pipe;
        logic        chk_res;
        logic [31:0] exp_res;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic        e;
        int          pc0, w, seen, diff;
        logic        saw;
        logic [31:0] expv;

        vecs[0] = '{2'd0, 64'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 0, 1'b0, 32'h0};
        vecs[1] = '{2'd3, 64'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 0, 1'b0, 32'h0};
        vecs[2] = '{2'd1, {32'h40800000, 32'h40400000}, 2,
                    32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 1'b0, 1, 1'b0, 32'h0};
        vecs[3] = '{2'd2, 64'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 0, 1'b1, 32'h41200000};
        vecs[4] = '{2'd1, {32'h40C00000, 32'h40A00000}, 2,
                    32'h3F000000, 32'h3E800000, 32'h3E800000, 32'h3F000000, 1'b0, 1, 1'b0, 32'h0};
        vecs[5] = '{2'd2, 64'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 0, 1'b1, 32'h41380000};
        vecs[6] = '{2'd0, 64'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 0, 1'b0, 32'h0};
        vecs[7] = '{2'd2, 64'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 0, 1'b1, 32'h0};

        // Reset and first GO/READ with cosine terms
        clk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_reset("reset");
        pc0 = pipe_cnt;
        cmd(2'd1, {32'h40000000, 32'h3F800000}, e);
        check("t1_go_err", e, 0);
        check("t1_go_pipe", pipe_cnt - pc0, 1);
        check("t1_pipe_x", pipe_x, {32'h40000000, 32'h3F800000});
        push(32'h3F000000, r2f($cos(1.0)));
        push(32'h3F800000, r2f($cos(2.0)));
        cmd(2'd2, 64'h0, e);
        check("t1_read_err", e, 0);
        expv = r2f(1.5 + $cos(1.0) + $cos(2.0));
        diff = int'(result) - int'(expv);
        if (diff < 0) diff = -diff;
        tests++;
        if (diff > 1) begin
            fails++;
            $display("FAIL t1_read_result: got %h expected %h (1 ulp)", result, expv);
        end

        // Command table
        for (int i = 0; i < 8; i++) begin
            pc0 = pipe_cnt;
            cmd(vecs[i].c, vecs[i].x, e);
            check($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
            check($sformatf("vec%0d_pipe", i), pipe_cnt - pc0, vecs[i].exp_pipe);
            if (vecs[i].exp_pipe != 0) check($sformatf("vec%0d_pipe_x", i), pipe_x, vecs[i].x);
            if (vecs[i].npush > 0) push(vecs[i].h0, vecs[i].c0);
            if (vecs[i].npush > 1) push(vecs[i].h1, vecs[i].c1);
            if (vecs[i].chk_res) check($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
        end

        // clk_en low: start ignored
        @(negedge clk);
        pc0 = pipe_cnt;
        clk_en = 1'b0; n = 2'd1; start = 1'b1;
        repeat (3) @(negedge clk);
        check("clken_busy", busy, 0);
        check("clken_pipe", pipe_cnt - pc0, 0);
        start = 1'b0; clk_en = 1'b1;

        // FIFO full back-pressure with a stalled adder
        add_stall = 1'b1;
        for (int i = 1; i <= 9; i++) push(r2f(real'(i)), r2f(real'(2 * i)));
        @(negedge clk);
        check("t3_full_ready", term_ready, 0);
        term_valid = 1'b1; term_half = r2f(10.0); term_cos = r2f(20.0);
        repeat (5) @(negedge clk);
        check("t3_held_ready", term_ready, 0);
        add_stall = 1'b0;
        w = 0;
        while (!term_ready && w < LIMIT) begin @(negedge clk); w++; end
        check("t3_ready_after_pop", term_ready, 1);
        @(posedge clk); #1;
        term_valid = 1'b0;
        cmd(2'd2, 64'h0, e);
        check("t3_read_err", e, 0);
        check("t3_result", result, r2f(165.0));

        // READ with three terms outstanding
        add_lat = 3;
        cmd(2'd1, 64'h1, e);
        cmd(2'd1, 64'h2, e);
        push(r2f(1.0), r2f(1.0));
        @(negedge clk);
        n = 2'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        saw = 1'b0;
        repeat (10) begin @(negedge clk); if (done) saw = 1'b1; end
        check("t5_no_early_done", saw, 0);
        check("t5_busy", busy, 1);
        push(r2f(2.0), r2f(2.0));
        push(r2f(3.0), r2f(3.0));
        push(r2f(4.0), r2f(4.0));
        w = 0;
        while (!done && w < LIMIT) begin @(negedge clk); w++; end
        check("t5_done_seen", done, 1);
        check("t5_err", err, 0);
        check("t5_result", result, r2f(185.0));
        @(negedge clk);

        // Pending-counter overflow rejection and reserved command
        add_lat = 2;
        saw = 1'b0;
        for (int k = 0; k < 127; k++) begin
            cmd(2'd1, 64'(k), e);
            if (e) saw = 1'b1;
        end
        check("t4_fill_err", saw, 0);
        pc0 = pipe_cnt;
        cmd(2'd1, 64'hDEAD, e);
        check("t4_overflow_err", e, 1);
        check("t4_overflow_no_pipe", pipe_cnt - pc0, 0);
        cmd(2'd3, 64'h0, e);
        check("t4_reserved_err", e, 1);
        check("t4_reserved_idle", busy, 0);
        cmd(2'd1, 64'hBEEF, e);
        check("t4_still_full_err", e, 1);
        check("t4_pipe_total", pipe_cnt - pc0, 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset during A_COS and READ_WAIT
        cmd(2'd1, {32'h40000000, 32'h3F800000}, e);
        push(32'h3F800000, 32'h40000000);
        push(32'h40400000, 32'h40800000);
        cmd(2'd2, 64'h0, e);
        check("t6_pre_result", result, 32'h41200000);
        add_lat = 6;
        @(negedge clk);
        term_valid = 1'b1; term_half = 32'h3F800000; term_cos = 32'h40000000;
        n = 2'd2; start = 1'b1;
        @(posedge clk); #1;
        term_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        seen = 0; w = 0;
        while (seen < 2 && w < 200) begin
            @(negedge clk);
            if (add_start) seen++;
            w++;
        end
        check("t6_second_add_seen", seen, 2);
        rst = 1'b0;
        @(negedge clk);
        check_outputs_reset("t6_reset");
        rst = 1'b1;
        add_lat = 2;
        repeat (12) @(negedge clk);
        cmd(2'd1, {32'h40C00000, 32'h40A00000}, e);
        check("t6_go_err", e, 0);
        check("t6_pipe_x", pipe_x, {32'h40C00000, 32'h40A00000});
        push(32'h3F000000, 32'h3E800000);
        push(32'h3E800000, 32'h3F000000);
        cmd(2'd2, 64'h0, e);
        check("t6_read_err", e, 0);
        check("t6_result", result, 32'h3FC00000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

endmodule
